// File: rtl/branch_resolve.sv
// Registered branch-decision stage: evaluates the RV32I branch condition,
// computes the redirect target and hands the result to fetch over a
// valid/ready handshake, with flush and wrap-around branch statistics.
module branch_resolve #(
    parameter int NUM_SIZE = 32,
    parameter int CNT_SIZE = 16
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                flush,
    input  logic                inValid,
    output logic                inReady,
    input  logic [2:0]          funct3,
    input  logic [NUM_SIZE-1:0] rs1Val,
    input  logic [NUM_SIZE-1:0] rs2Val,
    input  logic [NUM_SIZE-1:0] pc,
    input  logic [NUM_SIZE-1:0] imm,
    output logic                outValid,
    input  logic                outReady,
    output logic                taken,
    output logic [NUM_SIZE-1:0] target,
    output logic                misaligned,
    output logic                illegal,
    output logic [CNT_SIZE-1:0] branchCount,
    output logic [CNT_SIZE-1:0] takenCount
);

    // Branch condition; signed operands make the BLT/BGE compare two's complement.
    function automatic logic condEval(input logic [2:0] f,
                                      input logic signed [NUM_SIZE-1:0] a,
                                      input logic signed [NUM_SIZE-1:0] b);
        logic eq;
        logic lt;
        logic ltu;
        eq  = (a == b);
        lt  = (a < b);
        ltu = ($unsigned(a) < $unsigned(b));
        case (f)
            3'b000:  condEval = eq;
            3'b001:  condEval = !eq;
            3'b100:  condEval = lt;
            3'b101:  condEval = !lt;
            3'b110:  condEval = ltu;
            3'b111:  condEval = !ltu;
            default: condEval = 1'b0;
        endcase
    endfunction

    function automatic logic isIllegal(input logic [2:0] f);
        isIllegal = (f == 3'b010) || (f == 3'b011);
    endfunction

    logic signed [NUM_SIZE-1:0] rs1_p0;
    logic signed [NUM_SIZE-1:0] rs2_p0;
    logic                       taken_p0;
    logic                       ill_p0;
    logic                       mis_p0;
    logic        [NUM_SIZE-1:0] target_p0;

    logic                       vld_p1;
    logic                       taken_p1;
    logic                       ill_p1;
    logic                       mis_p1;
    logic        [NUM_SIZE-1:0] target_p1;
    logic        [CNT_SIZE-1:0] branchCnt;
    logic        [CNT_SIZE-1:0] takenCnt;

    logic inXfer;
    logic outXfer;

    assign rs1_p0 = rs1Val;
    assign rs2_p0 = rs2Val;

    assign inReady = !vld_p1 || outReady;
    assign inXfer  = inValid && inReady && !flush;
    assign outXfer = vld_p1 && outReady && !flush;

    // ---- stage p0: combinational condition and target evaluation ----
    // Illegal encodings fall through condEval as not-taken, so they steer to pc+4.
    always_comb begin
        ill_p0    = isIllegal(funct3);
        taken_p0  = condEval(funct3, rs1_p0, rs2_p0);
        target_p0 = taken_p0 ? (pc + imm) : (pc + NUM_SIZE'(4));
        mis_p0    = taken_p0 && (target_p0[1:0] != 2'b00);
    end

    // ---- stage p1: one-entry output register ----
    // Valid tracks the handshake; flush wins over any same-cycle capture.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (inXfer) begin
            vld_p1 <= 1'b1;
        end else if (outReady) begin
            vld_p1 <= 1'b0;
        end
    end

    // Result fields load only on an accepted request and otherwise keep their value.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            taken_p1  <= 1'b0;
            target_p1 <= '0;
            mis_p1    <= 1'b0;
            ill_p1    <= 1'b0;
        end else if (inXfer) begin
            taken_p1  <= taken_p0;
            target_p1 <= target_p0;
            mis_p1    <= mis_p0;
            ill_p1    <= ill_p0;
        end
    end

    // Statistics count completed handshakes and wrap naturally; flush never clears them.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            branchCnt <= '0;
            takenCnt  <= '0;
        end else if (outXfer) begin
            branchCnt <= branchCnt + CNT_SIZE'(1);
            if (taken_p1) begin
                takenCnt <= takenCnt + CNT_SIZE'(1);
            end
        end
    end

    assign outValid    = vld_p1;
    assign taken       = taken_p1;
    assign target      = target_p1;
    assign misaligned  = mis_p1;
    assign illegal     = ill_p1;
    assign branchCount = branchCnt;
    assign takenCount  = takenCnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: accepted requests push the reference
// result; a negedge monitor compares and retires entries on handshake/flush.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rstN;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [2:0]  funct3;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        outValid;
    logic        outReady;
    logic        taken;
    logic [31:0] target;
    logic        misaligned;
    logic        illegal;
    logic [15:0] branchCount;
    logic [15:0] takenCount;

    branch_resolve #(.NUM_SIZE(32), .CNT_SIZE(16)) dut (
        .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(inReady),
        .funct3(funct3), .rs1Val(rs1Val), .rs2Val(rs2Val), .pc(pc), .imm(imm),
        .outValid(outValid), .outReady(outReady), .taken(taken), .target(target),
        .misaligned(misaligned), .illegal(illegal),
        .branchCount(branchCount), .takenCount(takenCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
        logic        ill;
    } res_t;

    res_t        q[$];
    int          vecCount = 0;
    int          cmpCount = 0;
    int          errCount = 0;
    int          cyc = 0;
    logic        monEn = 1'b0;
    logic        expInReady = 1'b1;
    logic        acc = 1'b0;
    logic [15:0] expBranch = '0;
    logic [15:0] expTaken = '0;

    always @(posedge clk) cyc++;

    // Reference: branch rules applied to whole numbers.
    function automatic res_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] p, input logic [31:0] i);
        res_t       r;
        longint     sa;
        longint     sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'(a);
        ub = longint'(b);
        r.ill = 1'b0;
        case (f)
            3'd0:    r.tk = (ua == ub);
            3'd1:    r.tk = (ua != ub);
            3'd4:    r.tk = (sa < sb);
            3'd5:    r.tk = (sa >= sb);
            3'd6:    r.tk = (ua < ub);
            3'd7:    r.tk = (ua >= ub);
            default: begin r.tk = 1'b0; r.ill = 1'b1; end
        endcase
        if (r.tk) r.tgt = 32'((longint'(p) + longint'(i)) % 64'h1_0000_0000);
        else      r.tgt = 32'((longint'(p) + 4) % 64'h1_0000_0000);
        r.mis = r.tk && ((r.tgt % 4) != 0);
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: check held result and predicted control, then retire on handshake or flush.
    always @(negedge clk) begin
        if (monEn) begin
            expInReady = (q.size() == 0) || outReady;
            cmp("inReady", inReady, expInReady);
            cmp("outValid", outValid, q.size() != 0);
            cmp("branchCount", branchCount, expBranch);
            cmp("takenCount", takenCount, expTaken);
            if (q.size() != 0) begin
                cmp("taken", taken, q[0].tk);
                cmp("target", target, q[0].tgt);
                cmp("misaligned", misaligned, q[0].mis);
                cmp("illegal", illegal, q[0].ill);
                if (outReady && !flush) begin
                    expBranch = expBranch + 16'd1;
                    if (q[0].tk) expTaken = expTaken + 16'd1;
                end
                if (outReady || flush) void'(q.pop_front());
            end
        end
    end

    // Issue side: a request that will be accepted at the next edge pushes its expected result.
    always @(negedge clk) begin
        #1;
        acc = monEn && inValid && expInReady && !flush;
        if (acc) begin
            q.push_back(model(funct3, rs1Val, rs2Val, pc, imm));
            vecCount++;
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i);
        funct3 = f; rs1Val = a; rs2Val = b; pc = p; imm = i; inValid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #2;
            if (acc) begin
                @(posedge clk); #1;
                inValid = 1'b0;
                return;
            end
        end
        errCount++;
        $display("FAIL send_timeout: got no acceptance expected acceptance within 100 cycles");
        inValid = 1'b0;
    endtask

    task automatic randOps();
        funct3 = 3'($urandom_range(0, 7));
        rs1Val = $urandom;
        rs2Val = ($urandom_range(0, 3) == 0) ? rs1Val : $urandom;
        pc     = $urandom;
        imm    = $urandom;
    endtask

    initial begin
        int          c0;
        logic [15:0] bcSave;
        rstN = 1'b0; flush = 1'b0; inValid = 1'b1; outReady = 1'b1;
        funct3 = 3'd0; rs1Val = 32'd1; rs2Val = 32'd1; pc = 32'h40; imm = 32'h8;

        // Reset held with a request present: nothing captured.
        repeat (3) begin
            @(negedge clk); #3;
            cmp("rst_outValid", outValid, 1'b0);
            cmp("rst_branchCount", branchCount, 16'd0);
            cmp("rst_takenCount", takenCount, 16'd0);
            cmp("rst_inReady", inReady, 1'b1);
            cmp("rst_target", target, 32'd0);
        end
        inValid = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        monEn = 1'b1;

        // Signed vs unsigned compare.
        send(3'b100, 32'hFFFFFFFF, 32'd1, 32'h100, 32'hFFFFFFF0);
        @(negedge clk); #3;
        cmp("blt_taken", taken, 1'b1);
        cmp("blt_target", target, 32'hF0);
        @(posedge clk); #1;
        send(3'b110, 32'hFFFFFFFF, 32'd1, 32'h100, 32'hFFFFFFF0);
        @(negedge clk); #3;
        cmp("bltu_taken", taken, 1'b0);
        cmp("bltu_target", target, 32'h104);
        @(posedge clk); #1;

        // Backpressure with a second request waiting.
        outReady = 1'b0;
        send(3'b000, 32'h12345678, 32'h12345678, 32'h300, 32'h20);
        funct3 = 3'b001; rs1Val = 32'h87654321; rs2Val = 32'h12345678; pc = 32'h400; imm = 32'h10;
        inValid = 1'b1;
        repeat (3) begin
            @(negedge clk); #3;
            cmp("bp_outValid", outValid, 1'b1);
            cmp("bp_taken", taken, 1'b1);
            cmp("bp_inReady", inReady, 1'b0);
            cmp("bp_accept", acc, 1'b0);
        end
        @(posedge clk); #1;
        outReady = 1'b1;
        @(negedge clk); #3;
        cmp("bp_accept2", acc, 1'b1);
        @(posedge clk); #1;
        inValid = 1'b0;
        @(negedge clk); #3;
        cmp("bp2_taken", taken, 1'b1);
        cmp("bp2_target", target, 32'h410);
        @(posedge clk); #1;

        // Wrap, misalignment, illegal.
        send(3'b101, 32'd0, 32'd0, 32'hFFFFFFFC, 32'd8);
        @(negedge clk); #3;
        cmp("wrap_target", target, 32'h4);
        cmp("wrap_mis", misaligned, 1'b0);
        @(posedge clk); #1;
        send(3'b101, 32'd0, 32'd0, 32'hFFFFFFFC, 32'd6);
        @(negedge clk); #3;
        cmp("mis_target", target, 32'h2);
        cmp("mis_flag", misaligned, 1'b1);
        @(posedge clk); #1;
        send(3'b010, 32'd5, 32'd5, 32'h200, 32'h40);
        @(negedge clk); #3;
        cmp("ill_flag", illegal, 1'b1);
        cmp("ill_taken", taken, 1'b0);
        cmp("ill_target", target, 32'h204);
        @(posedge clk); #1;

        // Flush with a handshake and a new request in the same cycle.
        outReady = 1'b0;
        send(3'b000, 32'd7, 32'd7, 32'h500, 32'h4);
        @(negedge clk); #3;
        bcSave = branchCount;
        @(posedge clk); #1;
        randOps();
        inValid = 1'b1; outReady = 1'b1; flush = 1'b1;
        @(negedge clk); #3;
        cmp("flush_accept", acc, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; inValid = 1'b0;
        @(negedge clk); #3;
        cmp("flush_outValid", outValid, 1'b0);
        cmp("flush_branchCount", branchCount, bcSave);
        @(posedge clk); #1;

        // Back-to-back stream: one acceptance per cycle.
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            send(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
        end
        cmp("stream_cycles", 32'(cyc - c0), 32'd5);
        @(posedge clk); #1;

        // Random handshake, backpressure and flush traffic.
        for (int k = 0; k < 400; k++) begin
            randOps();
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while a result is held.
        outReady = 1'b0;
        send(3'b000, 32'd9, 32'd9, 32'h600, 32'h8);
        @(posedge clk); #3;
        monEn = 1'b0;
        rstN = 1'b0;
        #1;
        cmp("arst_outValid", outValid, 1'b0);
        cmp("arst_taken", taken, 1'b0);
        cmp("arst_target", target, 32'd0);
        cmp("arst_branchCount", branchCount, 16'd0);
        cmp("arst_takenCount", takenCount, 16'd0);
        q.delete();
        expBranch = '0;
        expTaken = '0;
        @(negedge clk);
        rstN = 1'b1;
        outReady = 1'b1;
        @(posedge clk); #1;
        monEn = 1'b1;

        // Counter wrap: stream until the count reaches all-ones, then one more.
        for (int k = 0; k < 70000 && expBranch != 16'hFFFF; k++) begin
            randOps();
            inValid = 1'b1;
            @(negedge clk); #3;
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        @(negedge clk); #3;
        cmp("wrap_full", branchCount, 16'hFFFF);
        @(negedge clk); #3;
        cmp("wrap_zero", branchCount, 16'h0000);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Registered branch-decision stage for the RV32I core. It consumes the two source operands and the branch funct3, evaluates the condition internally (eq / signed lt / unsigned lt), and computes the branch target.
- Hands a taken/not-taken plus target result to the fetch redirect logic over a valid/ready handshake.
- One-entry output register with backpressure, synchronous flush, and wrap-around branch statistics counters.

Parameters:
- NUM_SIZE, 32, operand / PC / immediate width in bits.
- CNT_SIZE, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstN  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of held result and of any same-cycle input transfer.
- inValid  input  1  branch request present.
- inReady  output  1  stage can accept a request this cycle.
- funct3  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal.
- rs1Val  input  NUM_SIZE  first operand.
- rs2Val  input  NUM_SIZE  second operand.
- pc  input  NUM_SIZE  PC of the branch.
- imm  input  NUM_SIZE  sign-extended B-immediate.
- outValid  output  1  result held.
- outReady  input  1  consumer accepts result.
- taken  output  1  condition true (0 when illegal).
- target  output  NUM_SIZE  pc+imm if taken, else pc+4.
- misaligned  output  1  taken and target[1:0] != 0.
- illegal  output  1  funct3 was 010 or 011.
- branchCount  output  CNT_SIZE  completed (handshaken) results.
- takenCount  output  CNT_SIZE  completed results with taken=1.

Behaviour:
- Reset (rstN low, async): outValid=0, taken=0, target=0, misaligned=0, illegal=0, branchCount=0, takenCount=0. Reset asserted mid-transfer discards the held result.
- inReady = !outValid || outReady (combinational). It does not depend on inValid or on flush.
- Input transfer: occurs when inValid && inReady && !flush. On that edge the following are captured and outValid<=1:
  - taken, target, misaligned, illegal, evaluated from that cycle's inputs.
  - Result visible the next cycle (latency 1).
- Hold: while outValid && !outReady, all result outputs remain stable and inReady=0.
- Drain: on outValid && outReady with no new transfer, outValid<=0 and the result fields keep their old values.
- Back-to-back: outValid && outReady && inValid in the same cycle replaces the result with no bubble, so throughput is 1 per cycle.
- Conditions:
  - eq = (rs1Val == rs2Val).
  - lt = signed rs1Val < rs2Val, two's complement over NUM_SIZE.
  - ltu = unsigned compare.
  - BEQ=eq, BNE=!eq, BLT=lt, BGE=!lt, BLTU=ltu, BGEU=!ltu.
- Arithmetic: pc+imm and pc+4 are both modulo 2^NUM_SIZE; carry out is discarded (wrap).
- Misalignment: misaligned only when taken. A not-taken pc+4 never flags.
- Illegal funct3: illegal=1, taken=0, target=pc+4, misaligned=0. The result is still delivered and counted in branchCount.
- flush: at the clock edge, outValid<=0. A simultaneous input transfer is suppressed. A simultaneous output handshake is not counted.
- Counters:
  - Increment on outValid && outReady && !flush; takenCount increments additionally if taken.
  - Both wrap 2^CNT_SIZE-1 -> 0.
  - Only rstN clears them; flush does not.

Test Plan:
- Reset: hold rstN=0 with inValid=1, then release. Expect outValid=0, counters=0, inReady=1, and no capture while reset is low.
- Signed vs unsigned: BLT, then BLTU, with rs1Val=32'hFFFFFFFF, rs2Val=1, pc=32'h100, imm=32'hFFFFFFF0.
  - BLT -> taken=1, target=32'hF0.
  - BLTU -> taken=0, target=32'h104.
- Backpressure: BEQ 12345678/12345678 with outReady=0 for 3 cycles.
  - outValid=1 and taken=1 are held stable; inReady=0.
  - A second request (BNE 87654321/12345678) is accepted only after outReady=1 and appears the next cycle with taken=1.
- Wrap / misaligned / illegal:
  - pc=32'hFFFFFFFC, BGE 0/0 taken, imm=8 -> target=32'h4, misaligned=0.
  - imm=6 -> misaligned=1.
  - funct3=010 -> illegal=1, taken=0, target=pc+4.
- Flush: assert flush together with an output handshake and a new inValid. Next cycle outValid=0 and branchCount unchanged.
- Streaming / counter wrap: 5 random back-to-back requests with outReady=1 give one result per cycle. Preloading branchCount to 16'hFFFF (via 65535 handshakes) then completing one more -> branchCount=0.
